// File: rtl/servant_pll_pkg.sv
// Shared definitions for the servant PLL reset/lock controller: state encodings
// and sizing helpers used by RTL and debug/firmware consumers alike.
package servant_pll_pkg;

   localparam int STATE_W = 2;

   typedef enum logic [STATE_W-1:0] {
      PLLRST    = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } pll_state_e;

   localparam logic [7:0] RELOCK_MAX = 8'd255;

   // Counter only ever holds values up to (largest parameter - 1).
   function automatic int cnt_width(input int a, input int b, input int c);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return (m < 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/servant_sync2.sv
// Two-flop synchronizer for a single asynchronous level input; reusable for
// any slow asynchronous status line entering the i_clk domain.
module servant_sync2 (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_d,
   output logic o_q
);

   logic meta_r;
   logic sync_r;

   // Synchronizer flop chain, cleared by the synchronous reset.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         meta_r <= 1'b0;
         sync_r <= 1'b0;
      end else begin
         meta_r <= i_d;
         sync_r <= meta_r;
      end
   end

   assign o_q = sync_r;

endmodule

// File: rtl/servant_pll_ctrl.sv
// PLL reset sequencer: pulses the PLL reset, waits for lock with timeout,
// qualifies lock stability, then releases the system reset.
module servant_pll_ctrl
   import servant_pll_pkg::*;
#(
   parameter int RST_CYCLES     = 16,
   parameter int TIMEOUT_CYCLES = 12000,
   parameter int STABLE_CYCLES  = 1200
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_locked,
   output logic               o_pll_rst,
   output logic               o_sys_rst,
   output logic               o_ready,
   output logic [7:0]         o_relock_cnt,
   output logic [STATE_W-1:0] o_state
);

   localparam int CNT_W = cnt_width(RST_CYCLES, TIMEOUT_CYCLES, STABLE_CYCLES);
   localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

   logic             lock_s;
   pll_state_e       state_r;
   pll_state_e       state_nxt_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_nxt_s;
   logic             relock_inc_s;
   logic [7:0]       relock_r;
   logic             pll_rst_r;
   logic             sys_rst_r;
   logic             ready_r;

   servant_sync2 u_lock_sync (
      .i_clk (i_clk),
      .i_rst (i_rst),
      .i_d   (i_locked),
      .o_q   (lock_s)
   );

   // Next-state, relock event and cycle counter decode.
   always_comb begin
      state_nxt_s  = state_r;
      relock_inc_s = 1'b0;
      cnt_nxt_s    = cnt_r;
      case (state_r)
         PLLRST: begin
            if (cnt_r == RST_LAST) state_nxt_s = WAIT_LOCK;
            else                   state_nxt_s = PLLRST;
         end
         WAIT_LOCK: begin
            if (lock_s) begin
               state_nxt_s = STABLE;
            end else if (cnt_r == TIMEOUT_LAST) begin
               state_nxt_s  = PLLRST;
               relock_inc_s = 1'b1;
            end else begin
               state_nxt_s = WAIT_LOCK;
            end
         end
         STABLE: begin
            if (!lock_s)                  state_nxt_s = WAIT_LOCK;
            else if (cnt_r == STABLE_LAST) state_nxt_s = RUN;
            else                          state_nxt_s = STABLE;
         end
         RUN: begin
            if (!lock_s) begin
               state_nxt_s  = PLLRST;
               relock_inc_s = 1'b1;
            end else begin
               state_nxt_s = RUN;
            end
         end
         default: state_nxt_s = PLLRST;
      endcase
      // RUN holds the counter so it can never run past its width.
      if (state_nxt_s != state_r) cnt_nxt_s = '0;
      else if (state_r == RUN)    cnt_nxt_s = cnt_r;
      else                        cnt_nxt_s = cnt_r + CNT_W'(1);
   end

   // State, counter, saturating relock count and registered Moore outputs.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r   <= PLLRST;
         cnt_r     <= '0;
         relock_r  <= 8'd0;
         pll_rst_r <= 1'b1;
         sys_rst_r <= 1'b1;
         ready_r   <= 1'b0;
      end else begin
         state_r   <= state_nxt_s;
         cnt_r     <= cnt_nxt_s;
         if (relock_inc_s && (relock_r != RELOCK_MAX)) relock_r <= relock_r + 8'd1;
         pll_rst_r <= (state_nxt_s == PLLRST);
         sys_rst_r <= (state_nxt_s != RUN);
         ready_r   <= (state_nxt_s == RUN);
      end
   end

   assign o_pll_rst    = pll_rst_r;
   assign o_sys_rst    = sys_rst_r;
   assign o_ready      = ready_r;
   assign o_relock_cnt = relock_r;
   assign o_state      = state_r;

endmodule

// File: doc/servant_pll_ctrl.md
SERVANT_PLL_CTRL -- requirements
Module: servant_pll_ctrl

Interface
REQ-001 Parameter: RST_CYCLES, 16, number of cycles o_pll_rst is held high per PLL reset pulse (>=2).
REQ-002 Parameter: TIMEOUT_CYCLES, 12000, cycles allowed in WAIT_LOCK before a PLL reset retry (1 ms at 12 MHz).
REQ-003 Parameter: STABLE_CYCLES, 1200, consecutive synchronized lock-high cycles required before release (100 us at 12 MHz).
REQ-004 i_clk  input  1  PLL reference clock (12 MHz, same net as the PLL input); the sole clock of the block.
REQ-005 i_rst  input  1  reset, synchronous to i_clk, active-high.
REQ-006 i_locked  input  1  PLL LOCK output, asynchronous to i_clk.
REQ-007 o_pll_rst  output  1  drives the PLL RST pin; the PLL instance is built with its reset pin enabled.
REQ-008 o_sys_rst  output  1  system reset request, i_clk domain; the consumer resynchronizes it into the PLL output clock domain.
REQ-009 o_ready  output  1  high only in state RUN.
REQ-010 o_relock_cnt  output  8  saturating count of lock losses plus lock timeouts.
REQ-011 o_state  output  2  current state encoding, for debug/LED use.

Function
REQ-012 i_locked SHALL pass through a two-flop synchronizer; all decisions use the synchronized lock_s only.
REQ-013 States SHALL be PLLRST=0, WAIT_LOCK=1, STABLE=2 and RUN=3, with one cycle counter that clears on every state entry.
REQ-014 All outputs SHALL be registered Moore outputs: o_pll_rst=1 only in PLLRST; o_sys_rst=1 in every state except RUN; o_ready equal to (state==RUN).
REQ-015 PLLRST SHALL last exactly RST_CYCLES cycles and then transition to WAIT_LOCK, regardless of lock_s.
REQ-016 WAIT_LOCK SHALL go to STABLE on lock_s=1; otherwise, when counter==TIMEOUT_CYCLES-1, it SHALL go to PLLRST and increment o_relock_cnt.
REQ-017 STABLE SHALL go to WAIT_LOCK on lock_s=0, without incrementing o_relock_cnt; when counter==STABLE_CYCLES-1 with lock_s=1, it SHALL go to RUN.
REQ-018 RUN SHALL go to PLLRST on lock_s=0 and increment o_relock_cnt; the o_sys_rst rise SHALL occur in the same cycle o_pll_rst rises.
REQ-019 A lock glitch of any length seen on lock_s in STABLE SHALL restart the stable qualification from zero.
REQ-020 o_relock_cnt SHALL saturate at 255 and never wrap; it clears only on i_rst.
REQ-021 The counter width SHALL be sized as clog2 of the largest of the three parameters; no arithmetic SHALL overflow for any legal parameter set.

Reset
REQ-022 On i_rst=1 at a clock edge: state=PLLRST, counter=0, synchronizer flops=0, o_relock_cnt=0, o_pll_rst=1, o_sys_rst=1, o_ready=0.
REQ-023 i_rst asserted mid-operation, in any state, SHALL abort that state and restart the full sequence from PLLRST, including clearing o_relock_cnt.
REQ-024 The first PLLRST after i_rst deasserts SHALL last the full RST_CYCLES, counted from the first non-reset cycle.

Structure
REQ-025 State encodings and the o_state width SHALL live in a shared package (servant_pll_pkg) so firmware/debug consumers match.
REQ-026 The two-flop synchronizer SHALL be a separate sub-module, servant_sync2, reusable for other asynchronous inputs.
REQ-027 The block SHALL contain no PLL primitive; top-level servant wiring connects o_pll_rst to the PLL and i_locked from it.

Verification (RST_CYCLES=4, TIMEOUT_CYCLES=20, STABLE_CYCLES=8)
REQ-028 Release i_rst, then raise i_locked 10 cycles later and hold it -> o_pll_rst high for 4 cycles; RUN/o_ready=1 after 2 sync + 1 + 8 cycles; o_relock_cnt=0.
REQ-029 Hold i_locked=0 -> o_pll_rst pulses of 4 cycles separated by 20 WAIT_LOCK cycles; o_relock_cnt increments once per timeout; o_sys_rst stays 1.
REQ-030 In STABLE, drop i_locked for 1 cycle at stable count 5 -> return to WAIT_LOCK, re-qualify a full 8 cycles; o_relock_cnt unchanged.
REQ-031 In RUN, drop i_locked -> 2 cycles later o_pll_rst=1, o_sys_rst=1 and o_ready=0 in the same cycle; o_relock_cnt increments by 1.
REQ-032 Force 300 timeouts -> o_relock_cnt reads 255 and holds; pulse i_rst in RUN -> state=PLLRST, o_relock_cnt=0 next cycle.
